// File: rtl/drive_cmd_slew.sv
// Speed/steer command to per-wheel slewed drive values.
// Reversal dwells at zero (brake); stop forces an e-stop state.
module drive_cmd_slew #(
  parameter int TICK_DIV  = 1000,
  parameter int STEP      = 8,
  parameter int ZERO_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic signed [10:0] cmd_spd,
  input  logic signed [10:0] cmd_steer,
  input  logic               stop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               at_target
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = $clog2(ZERO_HOLD + 1);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] MAXV = 12'sd1023;
  localparam logic signed [11:0] MINV = -12'sd1023;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] HOLD = DW'(ZERO_HOLD);

  typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [10:0] lft_q, lft_d, rht_q, rht_d;
  logic signed [10:0] lt_q, lt_d, rt_q, rt_d;
  logic [DW-1:0] ld_q, ld_d, rd_q, rd_d;
  logic at_q, at_d;
  logic acc, done;
  logic signed [11:0] sum_l, sum_r;
  logic [DW+10:0] lstep, rstep;

  function automatic logic signed [10:0] sat(
    input logic signed [11:0] v
  );
    logic signed [11:0] r;
    r = v;
    if (v > MAXV) r = MAXV;
    if (v < MINV) r = MINV;
    return r[10:0];
  endfunction

  // Returns {dwell, cur} after one tick.
  function automatic logic [DW+10:0] step_fn(
    input logic signed [10:0] cur,
    input logic signed [10:0] tgt,
    input logic [DW-1:0]      dw
  );
    logic signed [11:0] c, t, d, ad, ac, n;
    logic [DW-1:0] nd;
    c  = {cur[10], cur};
    t  = {tgt[10], tgt};
    n  = c;
    nd = dw;
    d  = t - c;
    ad = d[11] ? -d : d;
    ac = c[11] ? -c : c;
    if (dw != '0) begin
      nd = dw - 1'b1;
    end else if (c != '0 && (t == '0 || t[11] != c[11])) begin
      if (ac <= STEP_S) n = '0;
      else n = c[11] ? c + STEP_S : c - STEP_S;
      if (n == '0 && t != '0) nd = HOLD;
    end else begin
      if (ad <= STEP_S) n = t;
      else n = d[11] ? c - STEP_S : c + STEP_S;
    end
    return {nd, n[10:0]};
  endfunction

  assign cmd_rdy = ~stop & (state_q != ESTOP);
  assign acc     = cmd_vld & cmd_rdy;
  assign sum_l   = $signed({cmd_spd[10], cmd_spd})
                 + $signed({cmd_steer[10], cmd_steer});
  assign sum_r   = $signed({cmd_spd[10], cmd_spd})
                 - $signed({cmd_steer[10], cmd_steer});
  assign done    = (lft_q == lt_q) && (rht_q == rt_q)
                 && (ld_q == '0) && (rd_q == '0);
  assign lstep   = step_fn(lft_q, lt_q, ld_q);
  assign rstep   = step_fn(rht_q, rt_q, rd_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lft_q   <= '0;
      rht_q   <= '0;
      lt_q    <= '0;
      rt_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      at_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lft_q   <= lft_d;
      rht_q   <= rht_d;
      lt_q    <= lt_d;
      rt_q    <= rt_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      at_q    <= at_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ESTOP;
    end else begin
      case (state_q)
        IDLE:    if (acc) state_d = RAMP;
        RAMP:    if (!acc && done) state_d = IDLE;
        ESTOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    lft_d = lft_q;
    rht_d = rht_q;
    lt_d  = lt_q;
    rt_d  = rt_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    if (stop) begin
      cnt_d = '0;
      lft_d = '0;
      rht_d = '0;
      lt_d  = '0;
      rt_d  = '0;
      ld_d  = '0;
      rd_d  = '0;
    end else if (acc) begin
      lt_d  = sat(sum_l);
      rt_d  = sat(sum_r);
      cnt_d = '0;
    end else if (state_q == RAMP) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d         = '0;
        {ld_d, lft_d} = lstep;
        {rd_d, rht_d} = rstep;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    at_d = (lft_d == lt_d) && (rht_d == rt_d);
  end

  always_comb begin
    lft       = lft_q;
    rht       = rht_q;
    at_target = at_q;
  end

endmodule

// File: tb/tb_drive_cmd_slew.sv
// Scoreboard bench for drive_cmd_slew.
// Expected output changes are queued; a monitor pops on each change.
module tb_drive_cmd_slew;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_vld = 1'b0;
  logic cmd_rdy;
  logic signed [10:0] cmd_spd = '0;
  logic signed [10:0] cmd_steer = '0;
  logic stop = 1'b0;
  logic signed [10:0] lft, rht;
  logic at_target;

  drive_cmd_slew #(
    .TICK_DIV(4), .STEP(16), .ZERO_HOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .cmd_spd(cmd_spd),
    .cmd_steer(cmd_steer), .stop(stop),
    .lft(lft), .rht(rht), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
    int at;
    int gap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mark = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input int l, input int r,
                      input int at, input int gap);
    exp_t e;
    e.l = l; e.r = r; e.at = at; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic send(input int s, input int st);
    @(negedge clk);
    chk("rdy_before_send", int'(cmd_rdy), 1);
    cmd_spd = 11'(s);
    cmd_steer = 11'(st);
    cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    mark = cyc;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_q(input int maxc);
    int n;
    n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_at(input int maxc);
    int n;
    n = 0;
    while (at_target !== 1'b1 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("settle", int'(at_target), 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int pl, pr, gap;
    exp_t e;
    pl = 0;
    pr = 0;
    forever begin
      @(negedge clk);
      if (mon_on && ($signed(lft) != pl || $signed(rht) != pr)) begin
        gap = cyc - mark;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected act=(%0d,%0d,%0d) exp=none",
                   $signed(lft), $signed(rht), at_target);
        end else begin
          e = q.pop_front();
          if ($signed(lft) != e.l || $signed(rht) != e.r ||
              int'(at_target) != e.at || gap != e.gap) begin
            failures++;
            $display("FAIL step act=(%0d,%0d,%0d,g%0d) exp=(%0d,%0d,%0d,g%0d)",
                     $signed(lft), $signed(rht), at_target, gap,
                     e.l, e.r, e.at, e.gap);
          end
        end
        mark = cyc;
      end
      pl = $signed(lft);
      pr = $signed(rht);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_lft", $signed(lft), 0);
    chk("rst_rht", $signed(rht), 0);
    chk("rst_at", int'(at_target), 1);
    chk("rst_rdy", int'(cmd_rdy), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 mon_on = 1'b1;

    for (int i = 1; i <= 6; i++) push(16 * i, 16 * i, 0, 4);
    push(100, 100, 1, 4);
    send(100, 0);
    chk("acc_at_low", int'(at_target), 0);
    wait_q(60);

    push(84, 84, 0, 4);
    push(68, 68, 0, 4);
    push(52, 52, 0, 4);
    push(40, 40, 1, 4);
    send(40, 0);
    wait_q(40);

    push(24, 24, 0, 4);
    push(8, 8, 0, 4);
    push(0, 0, 0, 4);
    push(-16, -16, 0, 12);
    push(-32, -32, 0, 4);
    push(-40, -40, 1, 4);
    send(-40, 0);
    wait_q(80);

    push(-24, -24, 0, 4);
    push(-8, -8, 0, 4);
    push(0, 0, 1, 4);
    send(0, 0);
    wait_q(40);

    push(16, 16, 0, 4);
    push(20, 20, 1, 4);
    send(20, 0);
    wait_q(40);

    push(4, 4, 0, 4);
    push(0, 0, 1, 4);
    send(0, 0);
    wait_q(40);

    push(16, 16, 0, 4);
    push(32, 32, 0, 4);
    push(48, 48, 0, 4);
    send(100, 0);
    wait_q(40);
    push(32, 32, 0, 4);
    push(20, 20, 1, 4);
    send(20, 0);
    wait_q(40);

    mon_on = 1'b0;
    send(900, 300);
    wait_at(600);
    chk("sat_lft", $signed(lft), 1023);
    chk("sat_rht", $signed(rht), 600);
    send(-1024, 0);
    wait_at(1200);
    chk("neg_lft", $signed(lft), -1023);
    chk("neg_rht", $signed(rht), -1023);

    send(100, 0);
    repeat (12) @(negedge clk);
    chk("mid_nonzero", int'($signed(lft) != 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_lft", $signed(lft), 0);
    chk("mid_rst_rht", $signed(rht), 0);
    chk("mid_rst_at", int'(at_target), 1);
    chk("mid_rst_rdy", int'(cmd_rdy), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 mon_on = 1'b1;

    for (int i = 1; i <= 4; i++) push(16 * i, 16 * i, 0, 4);
    send(100, 0);
    wait_q(40);
    push(0, 0, 1, 0);
    stop = 1'b1;
    cmd_vld = 1'b1;
    cmd_spd = 11'sd100;
    #1;
    chk("stop_rdy", int'(cmd_rdy), 0);
    @(posedge clk);
    #1 mark = cyc;
    repeat (10) @(negedge clk);
    chk("estop_lft", $signed(lft), 0);
    chk("estop_rht", $signed(rht), 0);
    chk("estop_rdy", int'(cmd_rdy), 0);
    chk("estop_q", q.size(), 0);
    stop = 1'b0;
    cmd_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("exit_at", int'(at_target), 1);
    chk("exit_lft", $signed(lft), 0);
    chk("exit_rdy", int'(cmd_rdy), 1);

    push(-16, -16, 0, 4);
    push(-32, -32, 0, 4);
    push(-40, -48, 0, 4);
    push(-40, -60, 1, 4);
    send(-50, 10);
    wait_q(40);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drive_cmd_slew.md
Name: drive_cmd_slew

Overview:
Upstream command stage for the motor controller. Converts a signed speed/steer command into per-wheel signed 11-bit drive values `lft`/`rht`, which feed the motor controller directly. Each wheel output ramps toward its target at a fixed slew rate, with saturation. On direction reversal, the wheel dwells at zero, which the motor controller treats as brake. An emergency-stop input overrides everything.

Parameters:
TICK_DIV, 1000, clk cycles per slew tick (>=2)
STEP, 8, max magnitude change per wheel per tick (1..511)
ZERO_HOLD, 4, ticks a wheel holds 0 when reversing direction (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_vld  input  1  new command present
cmd_rdy  output  1  command accepted when cmd_vld & cmd_rdy; combinational = ~stop & (state != ESTOP)
cmd_spd  input  11  signed 2's-complement forward speed
cmd_steer  input  11  signed steer; positive turns right (left wheel faster)
stop  input  1  synchronous emergency stop, level
lft  output  11  signed left-wheel drive, registered
rht  output  11  signed right-wheel drive, registered
at_target  output  1  registered; 1 when lft==lft_tgt and rht==rht_tgt

Behaviour:
- Reset (async, rst=1):
  - lft=rht=0; lft_tgt=rht_tgt=0.
  - Tick counter 0; dwell counters 0; state IDLE; at_target=1.
- Targets are computed in 12-bit signed arithmetic: lft_tgt = sat(spd+steer), rht_tgt = sat(spd-steer).
  - sat clamps to [-1023, +1023]. -1024 is never produced.
- Accept: on the clock edge where cmd_vld & cmd_rdy:
  - Targets are registered, the tick counter is cleared, and state goes to RAMP.
  - Acceptance in RAMP retargets and restarts the tick phase.
  - Dwell counters in progress are not affected by acceptance.
- Ticks: the tick counter runs only in RAMP.
  - A tick fires when the counter reaches TICK_DIV-1; the counter then wraps to 0.
  - The first step occurs TICK_DIV cycles after acceptance.
- Per-wheel step on each tick (independent, cur = current output, tgt = target):
  - If the wheel's dwell count is nonzero: decrement it and hold cur.
  - Else if cur != 0 and tgt is 0 or of opposite sign: move toward 0 by STEP, clamping at 0. Do not pass zero.
  - Else: if |tgt-cur| <= STEP, cur = tgt; otherwise cur moves by STEP toward tgt.
  - Dwell load: if this tick moves cur from nonzero to 0 and tgt is nonzero, the dwell count loads ZERO_HOLD. Arriving at 0 with tgt==0 loads no dwell. Starting from 0 toward any tgt loads no dwell.
- FSM states and transitions:
  - IDLE: outputs held. Goes to RAMP on accept.
  - RAMP: goes to IDLE on the cycle after both wheels equal their targets and both dwell counts are 0.
  - ESTOP: entered from any state when stop=1.
    - Entry: next edge sets lft=rht=0, targets=0, dwell=0, tick counter=0.
    - Held while stop=1. cmd_vld is ignored (cmd_rdy=0).
    - When stop is sampled 0: goes to IDLE, with at_target=1.
- Simultaneous events:
  - stop and cmd_vld on the same cycle: stop wins; the command is dropped.
  - rst has priority over everything.
- at_target is registered from next-state values, so it updates on the same edge as lft/rht.
- Outputs change only on tick edges, accept edges (targets only), or ESTOP entry.

Test Plan:
All scenarios use TICK_DIV=4, STEP=16, ZERO_HOLD=2 unless stated.
- Reset: assert rst mid-ramp -> lft=rht=0 and at_target=1 asynchronously; cmd_rdy=1 with stop=0.
- Ramp: spd=100, steer=0 accepted -> lft=rht steps 16,32,48,64,80,96,100, one step every 4 cycles, first step 4 cycles after acceptance; at_target=1 on the 100 edge; state IDLE next cycle.
- Saturation: spd=900, steer=300 -> lft_tgt=1023, rht_tgt=600. spd=-1024, steer=0 -> both targets -1023. Check steady-state outputs.
- Reversal: lft settled at 40, new cmd spd=-40 -> lft sequence 24,8,0, then 0 for 2 ticks, then -16,-32,-40. There is no dwell when the target is 0.
- Retarget mid-ramp: at lft=48 heading to 100, accept spd=20 -> next step 4 cycles later gives 32, then 20; at_target=1.
- E-stop: stop=1 during ramp at lft=64 -> next edge lft=rht=0; cmd_rdy=0; cmd_vld ignored for 10 cycles. stop=0 -> IDLE with at_target=1 and outputs 0; a following accept ramps normally.
